// File: rtl/ternary_sum_tree_acc.sv
// ternary_sum_tree_acc: pipelined NCHAN-input unsigned adder tree of registered
// 3:1 adds, followed by a windowed accumulator over ACC_LEN valid tree outputs.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   dat_i        packed inputs, channel k = dat_i[k*INBITS +: INBITS]
//   valid_i      dat_i qualifier
//   clear_i      abort the current accumulator window
//   sum_o        exact tree sum, NSTAGE cycles after dat_i
//   sum_valid_o  sum_o qualifier
//   acc_o        last completed window total (held)
//   acc_valid_o  one-cycle strobe when acc_o updates
//   ovf_o        only with TERN_ACC_SATURATE_EN: the held window clamped
//
// Optional feature macro: TERN_ACC_SATURATE_EN (saturating accumulator + ovf_o).
// Without it the accumulator wraps modulo 2^ACCBITS.
module ternary_sum_tree_acc #(
    parameter  int NCHAN   = 8,
    parameter  int INBITS  = 5,
    parameter  int ACC_LEN = 4,
    parameter  int ACCBITS = 10,
    localparam int SUMBITS = INBITS + $clog2(NCHAN)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NCHAN*INBITS-1:0]   dat_i,
    input  logic                      valid_i,
    input  logic                      clear_i,
    output logic [SUMBITS-1:0]        sum_o,
    output logic                      sum_valid_o,
    output logic [ACCBITS-1:0]        acc_o,
    output logic                      acc_valid_o
`ifdef TERN_ACC_SATURATE_EN
    ,
    output logic                      ovf_o
`endif
);

    // Number of terms alive after s ternary reduction stages.
    function automatic int nterms(input int s);
        int n;
        n = NCHAN;
        for (int i = 0; i < s; i++) n = (n + 2) / 3;
        return n;
    endfunction

    function automatic int calc_nstage();
        int n;
        int s;
        n = NCHAN;
        s = 0;
        while (n > 1) begin
            n = (n + 2) / 3;
            s++;
        end
        return (s < 1) ? 1 : s;
    endfunction

    localparam int NSTAGE = calc_nstage();
    localparam int CNTW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(ACC_LEN - 1);

    typedef logic [SUMBITS-1:0] word_t;

    // Every stage is carried at full SUMBITS width, so no stage can truncate.
    word_t             lvl0   [NCHAN];
    word_t             tree_d [NSTAGE][NCHAN];
    word_t             tree_q [NSTAGE][NCHAN];
    logic [NSTAGE-1:0] vld_d, vld_q;

    always_comb begin
        for (int k = 0; k < NCHAN; k++) begin
            lvl0[k] = SUMBITS'(dat_i[k*INBITS +: INBITS]);
        end
    end

    // Terms 3j..3j+2 of stage s feed term j of stage s+1; a short last
    // group (1 or 2 terms) simply passes or adds what exists.
    always_comb begin
        for (int s = 0; s < NSTAGE; s++) begin
            for (int j = 0; j < NCHAN; j++) begin
                tree_d[s][j] = '0;
                if (j < nterms(s + 1)) begin
                    for (int t = 0; t < 3; t++) begin
                        int idx;
                        idx = 3 * j + t;
                        if (idx < nterms(s)) begin
                            if (s == 0) begin
                                tree_d[s][j] = tree_d[s][j] + lvl0[idx];
                            end else begin
                                tree_d[s][j] = tree_d[s][j]
                                             + tree_q[(s == 0) ? 0 : s - 1][idx];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        vld_d[0] = valid_i;
        for (int s = 1; s < NSTAGE; s++) vld_d[s] = vld_q[s-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int s = 0; s < NSTAGE; s++) begin
                for (int j = 0; j < NCHAN; j++) tree_q[s][j] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int s = 0; s < NSTAGE; s++) begin
                for (int j = 0; j < NCHAN; j++) tree_q[s][j] <= tree_d[s][j];
            end
        end
    end

    assign sum_o       = tree_q[NSTAGE-1][0];
    assign sum_valid_o = vld_q[NSTAGE-1];

    logic [CNTW-1:0]    cnt_d, cnt_q, base_cnt;
    logic [ACCBITS-1:0] acc_d, acc_q, base_acc, acc_new;
    logic [ACCBITS-1:0] res_d, res_q;
    logic               stb_d, stb_q;

`ifdef TERN_ACC_SATURATE_EN
    localparam int WIDE = ((ACCBITS > SUMBITS) ? ACCBITS : SUMBITS) + 1;
    logic [WIDE-1:0] acc_wide;
    logic            clamp, base_ovf;
    logic            wovf_d, wovf_q, ovf_d, ovf_q;
`endif

    always_comb begin
        // clear_i restarts the window, so a coincident beat becomes beat 0.
        base_cnt = clear_i ? '0 : cnt_q;
        base_acc = (base_cnt == '0) ? '0 : acc_q;
`ifdef TERN_ACC_SATURATE_EN
        base_ovf = (base_cnt == '0) ? 1'b0 : wovf_q;
        acc_wide = WIDE'(base_acc) + WIDE'(sum_o);
        clamp    = acc_wide > WIDE'({ACCBITS{1'b1}});
        acc_new  = clamp ? '1 : acc_wide[ACCBITS-1:0];
        wovf_d   = wovf_q;
        ovf_d    = ovf_q;
`else
        acc_new  = base_acc + ACCBITS'(sum_o);
`endif
        cnt_d = base_cnt;
        acc_d = acc_q;
        res_d = res_q;
        stb_d = 1'b0;
        if (sum_valid_o) begin
            if (base_cnt == LAST) begin
                cnt_d = '0;
                res_d = acc_new;
                stb_d = 1'b1;
`ifdef TERN_ACC_SATURATE_EN
                ovf_d = base_ovf | clamp;
`endif
            end else begin
                cnt_d = base_cnt + 1'b1;
                acc_d = acc_new;
`ifdef TERN_ACC_SATURATE_EN
                wovf_d = base_ovf | clamp;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            stb_q  <= 1'b0;
`ifdef TERN_ACC_SATURATE_EN
            wovf_q <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            stb_q  <= stb_d;
`ifdef TERN_ACC_SATURATE_EN
            wovf_q <= wovf_d;
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign acc_o       = res_q;
    assign acc_valid_o = stb_q;
`ifdef TERN_ACC_SATURATE_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_ternary_sum_tree_acc.sv
// Bench for ternary_sum_tree_acc: default build (8x5b, window 4) plus a
// 9-bit accumulator copy, checked against a cycle-level arithmetic model.
module tb_ternary_sum_tree_acc;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, clear_i;
    logic [39:0] dat_i;
    logic [7:0]  sum_o, sum9_o;
    logic        sum_valid_o, sum9_valid_o;
    logic [9:0]  acc_o;
    logic [8:0]  acc9_o;
    logic        acc_valid_o, acc9_valid_o;
`ifdef TERN_ACC_SATURATE_EN
    logic        ovf_o, ovf9_o;
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    ternary_sum_tree_acc u_dut (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .valid_i(valid_i),
        .clear_i(clear_i), .sum_o(sum_o), .sum_valid_o(sum_valid_o),
        .acc_o(acc_o), .acc_valid_o(acc_valid_o)
`ifdef TERN_ACC_SATURATE_EN
        , .ovf_o(ovf_o)
`endif
    );

    ternary_sum_tree_acc #(.ACCBITS(9)) u_dut9 (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .valid_i(valid_i),
        .clear_i(clear_i), .sum_o(sum9_o), .sum_valid_o(sum9_valid_o),
        .acc_o(acc9_o), .acc_valid_o(acc9_valid_o)
`ifdef TERN_ACC_SATURATE_EN
        , .ovf_o(ovf9_o)
`endif
    );

    // Model state: a 2-deep delay line for the tree, a plain window sum.
    int pipe_s[$];
    bit pipe_v[$];
    int m_sum, m_acc, m_acc9, w_sum, w_cnt, strobes;
    bit m_sv, m_stb, m_ovf9;
    int n_chk = 0;
    int n_fail = 0;

    function automatic int chsum(input logic [39:0] d);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(d[k*5 +: 5]);
        return s;
    endfunction

    function automatic logic [39:0] mk2(input int a, input int b);
        logic [39:0] d;
        d = '0;
        d[9:5] = 5'(a);
        d[4:0] = 5'(b);
        return d;
    endfunction

    task automatic model_reset();
        pipe_s = {0};
        pipe_v = {1'b0};
        m_sum = 0; m_sv = 1'b0; m_acc = 0; m_acc9 = 0;
        m_stb = 1'b0; m_ovf9 = 1'b0; w_sum = 0; w_cnt = 0;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; dat_i = '0;
        repeat (n) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    // Drive one cycle and advance the model past the same edge.
    task automatic step(input logic [39:0] d, input bit v, input bit c);
        dat_i = d; valid_i = v; clear_i = c;
        @(posedge clk);
        #1;
        m_stb = 1'b0;
        if (c) begin w_sum = 0; w_cnt = 0; end
        if (m_sv) begin
            w_sum += m_sum;
            w_cnt++;
            if (w_cnt == 4) begin
                m_acc  = w_sum;
                m_acc9 = SAT ? ((w_sum > 511) ? 511 : w_sum) : (w_sum % 512);
                m_ovf9 = SAT && (w_sum > 511);
                m_stb  = 1'b1;
                strobes++;
                w_sum = 0; w_cnt = 0;
            end
        end
        m_sum = pipe_s.pop_front();
        m_sv  = pipe_v.pop_front();
        pipe_s.push_back(chsum(d));
        pipe_v.push_back(v);
    endtask

    task automatic test_reset();
        do_reset(2);
        n_chk++;
        if ({sum_o, sum_valid_o, acc_o, acc_valid_o} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got sum=%0d sv=%b acc=%0d av=%b want 0",
                     sum_o, sum_valid_o, acc_o, acc_valid_o);
        end
        n_chk++;
        if ({acc9_o, acc9_valid_o, sum9_valid_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_acc9 got acc9=%0d av=%b want 0", acc9_o, acc9_valid_o);
        end
    endtask

    task automatic test_ramp();
        do_reset(1);
        for (int i = 0; i < 33; i++) begin
            step((i < 31) ? {8{5'(i)}} : 40'd0, i < 31, 1'b0);
            n_chk++;
            if ({sum_valid_o, acc_valid_o} !== {m_sv, m_stb}) begin
                n_fail++;
                $display("FAIL ramp_valids got %b want %b",
                         {sum_valid_o, acc_valid_o}, {m_sv, m_stb});
            end
            if (m_sv) begin
                n_chk++;
                if (sum_o !== 8'(m_sum) || sum9_o !== 8'(m_sum)) begin
                    n_fail++;
                    $display("FAIL ramp_sum got %0d/%0d want %0d", sum_o, sum9_o, m_sum);
                end
            end
            n_chk++;
            if (acc_o !== 10'(m_acc)) begin
                n_fail++;
                $display("FAIL ramp_acc got %0d want %0d", acc_o, m_acc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last, nstb;
        do_reset(1);
        last = -1; nstb = 0;
        for (int i = 0; i < 20; i++) begin
            step({8{5'd31}}, i < 16, 1'b0);
            n_chk++;
            if (acc_valid_o !== m_stb) begin
                n_fail++;
                $display("FAIL b2b_strobe cyc=%0d got %b want %b", i, acc_valid_o, m_stb);
            end
            if (acc_valid_o) begin
                nstb++;
                n_chk++;
                if (acc_o !== 10'd992 || acc9_o !== (SAT ? 9'd511 : 9'd480)) begin
                    n_fail++;
                    $display("FAIL b2b_total got %0d/%0d want 992/%0d",
                             acc_o, acc9_o, SAT ? 511 : 480);
                end
`ifdef TERN_ACC_SATURATE_EN
                n_chk++;
                if ({ovf_o, ovf9_o} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL b2b_ovf got %b want 01", {ovf_o, ovf9_o});
                end
`endif
                if (last >= 0) begin
                    n_chk++;
                    if (i - last != 4) begin
                        n_fail++;
                        $display("FAIL b2b_gap got %0d want 4", i - last);
                    end
                end
                last = i;
            end
        end
        n_chk++;
        if (nstb != 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 4", nstb);
        end
    endtask

    task automatic test_gaps_clear();
        int vals[19] = '{10, 0, 20, 0, 0, 0, 0, 0, 30, 0, 40, 0, 50, 0, 60,
                         0, 0, 0, 0};
        int nstb, got;
        do_reset(1);
        nstb = 0; got = -1;
        for (int i = 0; i < 19; i++) begin
            logic [39:0] d;
            d = (vals[i] > 31) ? mk2(vals[i] / 2, vals[i] / 2) : 40'(vals[i]);
            step(d, vals[i] != 0, i == 6);
            n_chk++;
            if ({acc_valid_o, acc_o} !== {m_stb, 10'(m_acc)}) begin
                n_fail++;
                $display("FAIL gaps_acc got %b/%0d want %b/%0d",
                         acc_valid_o, acc_o, m_stb, m_acc);
            end
            if (acc_valid_o) begin nstb++; got = int'(acc_o); end
        end
        n_chk++;
        if (nstb != 1 || got != 180) begin
            n_fail++;
            $display("FAIL gaps_result got %0d strobes acc=%0d want 1 acc=180", nstb, got);
        end
    endtask

    task automatic test_clear_coincident();
        int vals[12] = '{5, 5, 7, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        int nstb, got;
        do_reset(1);
        nstb = 0; got = -1;
        for (int i = 0; i < 12; i++) begin
            step(40'(vals[i]), vals[i] != 0, i == 4);
            n_chk++;
            if ({acc_valid_o, acc_o} !== {m_stb, 10'(m_acc)}) begin
                n_fail++;
                $display("FAIL coinc_acc got %b/%0d want %b/%0d",
                         acc_valid_o, acc_o, m_stb, m_acc);
            end
            if (acc_valid_o) begin nstb++; got = int'(acc_o); end
        end
        n_chk++;
        if (nstb != 1 || got != 10) begin
            n_fail++;
            $display("FAIL coinc_result got %0d strobes acc=%0d want 1 acc=10", nstb, got);
        end
    endtask

    task automatic test_reset_mid();
        int got;
        do_reset(1);
        got = -1;
        for (int i = 0; i < 4; i++) step({8{5'd31}}, 1'b1, 1'b0);
        do_reset(1);
        n_chk++;
        if ({sum_o, sum_valid_o, acc_o, acc_valid_o} !== 20'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got sum=%0d sv=%b acc=%0d av=%b want 0",
                     sum_o, sum_valid_o, acc_o, acc_valid_o);
        end
        for (int i = 0; i < 8; i++) begin
            step({8{5'd1}}, i < 4, 1'b0);
            n_chk++;
            if ({sum_valid_o, acc_valid_o} !== {m_sv, m_stb}) begin
                n_fail++;
                $display("FAIL rstmid_valids cyc=%0d got %b want %b",
                         i, {sum_valid_o, acc_valid_o}, {m_sv, m_stb});
            end
            if (acc_valid_o) got = int'(acc_o);
        end
        n_chk++;
        if (got != 32) begin
            n_fail++;
            $display("FAIL rstmid_window got %0d want 32", got);
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            logic [39:0] d;
            for (int k = 0; k < 8; k++) d[k*5 +: 5] = 5'($urandom_range(0, 31));
            step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            n_chk++;
            if ({sum_valid_o, acc_valid_o, acc_o, acc9_o}
                !== {m_sv, m_stb, 10'(m_acc), 9'(m_acc9)}) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d got sv=%b av=%b acc=%0d acc9=%0d want %b %b %0d %0d",
                         i, sum_valid_o, acc_valid_o, acc_o, acc9_o,
                         m_sv, m_stb, m_acc, m_acc9);
            end
            if (m_sv) begin
                n_chk++;
                if (sum_o !== 8'(m_sum)) begin
                    n_fail++;
                    $display("FAIL rand_sum cyc=%0d got %0d want %0d", i, sum_o, m_sum);
                end
            end
`ifdef TERN_ACC_SATURATE_EN
            n_chk++;
            if ({ovf_o, ovf9_o} !== {1'b0, m_ovf9}) begin
                n_fail++;
                $display("FAIL rand_ovf got %b want %b", {ovf_o, ovf9_o}, {1'b0, m_ovf9});
            end
`endif
        end
    endtask

    initial begin
        strobes = 0;
        rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; dat_i = '0;
        model_reset();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_gaps_clear();
        test_clear_coincident();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
